// File: rtl/mirfak_id_skid_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mirfak_id_skid_stage                                                     |
// | ID/EX boundary: operand bypass, branch resolve, 2-entry skid to EX.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mirfak_id_skid_stage #(
  parameter int XLEN   = 32,
  parameter int NFWD   = 3,
  parameter int CTRL_W = 32,
  parameter int SELW   = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   id_valid_i,
  output logic                   id_ready_o,
  input  logic [XLEN-1:0]        id_pc_i,
  input  logic [31:0]            id_instruction_i,
  input  logic [XLEN-1:0]        id_imm_i,
  input  logic [XLEN-1:0]        id_rs1_data_i,
  input  logic [XLEN-1:0]        id_rs2_data_i,
  input  logic [NFWD*XLEN-1:0]   id_fwd_data_i,
  input  logic [SELW-1:0]        id_fwd_a_sel_i,
  input  logic [SELW-1:0]        id_fwd_b_sel_i,
  input  logic [1:0]             id_sel_op_a_i,
  input  logic [1:0]             id_sel_op_b_i,
  input  logic [2:0]             id_br_op_i,
  input  logic                   id_is_jalr_i,
  input  logic [CTRL_W-1:0]      id_control_i,
  output logic                   ex_valid_o,
  input  logic                   ex_ready_i,
  output logic [XLEN-1:0]        ex_pc_o,
  output logic [XLEN-1:0]        ex_operand_a_o,
  output logic [XLEN-1:0]        ex_operand_b_o,
  output logic [XLEN-1:0]        ex_store_data_o,
  output logic [31:0]            ex_instruction_o,
  output logic [CTRL_W-1:0]      ex_control_o,
  output logic                   ex_exception_o,
  output logic [XLEN-1:0]        ex_mtval_o,
  output logic                   take_branch_o,
  output logic [XLEN-1:0]        pc_bj_target_o
);

  localparam logic [31:0] C_NOP      = 32'h00000013;
  localparam logic [2:0]  C_BR_NONE  = 3'd0;
  localparam logic [2:0]  C_BR_BEQ   = 3'd1;
  localparam logic [2:0]  C_BR_BNE   = 3'd2;
  localparam logic [2:0]  C_BR_JUMP  = 3'd3;
  localparam logic [2:0]  C_BR_BLT   = 3'd4;
  localparam logic [2:0]  C_BR_BGE   = 3'd5;
  localparam logic [2:0]  C_BR_BLTU  = 3'd6;
  localparam logic [2:0]  C_BR_BGEU  = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   store;
    logic [31:0]       instr;
    logic [CTRL_W-1:0] ctrl;
    logic              exc;
    logic [XLEN-1:0]   mtval;
  } bundle_t;

  function automatic bundle_t f_rst_bundle();
    bundle_t b;
    b       = '0;
    b.instr = C_NOP;
    return b;
  endfunction

  logic [XLEN-1:0] w_byp [NFWD];
  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_op_b;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic            w_cond;
  logic            w_accept;
  logic            w_transfer;
  logic            w_misaligned;
  bundle_t         w_new;

  logic            r_main_valid;
  logic            r_skid_valid;
  bundle_t         r_main;
  bundle_t         r_skid;

  generate
    for (genvar k = 0; k < NFWD; k++) begin : g_byp
      assign w_byp[k] = id_fwd_data_i[k*XLEN +: XLEN];
    end
  endgenerate

  // Out-of-range selects leave the operand undefined rather than aliasing a source.
  always_comb begin
    w_fwd_a = (id_fwd_a_sel_i == '0) ? id_rs1_data_i : 'x;
    w_fwd_b = (id_fwd_b_sel_i == '0) ? id_rs2_data_i : 'x;
    for (int k = 0; k < NFWD; k++) begin
      if (id_fwd_a_sel_i == SELW'(k + 1)) w_fwd_a = w_byp[k];
      if (id_fwd_b_sel_i == SELW'(k + 1)) w_fwd_b = w_byp[k];
    end
  end

  always_comb begin
    w_op_a = w_fwd_a;
    case (id_sel_op_a_i)
      2'd0:    w_op_a = w_fwd_a;
      2'd1:    w_op_a = id_pc_i;
      2'd2:    w_op_a = id_pc_i + XLEN'(4);
      default: w_op_a = '0;
    endcase
  end

  always_comb begin
    w_op_b = w_fwd_b;
    case (id_sel_op_b_i)
      2'd0:    w_op_b = w_fwd_b;
      2'd1:    w_op_b = id_imm_i;
      2'd2:    w_op_b = XLEN'(4);
      default: w_op_b = '0;
    endcase
  end

  assign w_eq  = (w_fwd_a == w_fwd_b);
  assign w_lt  = ($signed(w_fwd_a) < $signed(w_fwd_b));
  assign w_ltu = (w_fwd_a < w_fwd_b);

  always_comb begin
    w_cond = 1'b0;
    case (id_br_op_i)
      C_BR_NONE: w_cond = 1'b0;
      C_BR_BEQ:  w_cond = w_eq;
      C_BR_BNE:  w_cond = !w_eq;
      C_BR_JUMP: w_cond = 1'b1;
      C_BR_BLT:  w_cond = w_lt;
      C_BR_BGE:  w_cond = !w_lt;
      C_BR_BLTU: w_cond = w_ltu;
      C_BR_BGEU: w_cond = !w_ltu;
      default:   w_cond = 1'b0;
    endcase
  end

  assign w_jalr_sum = w_fwd_a + id_imm_i;
  assign w_target   = id_is_jalr_i ? {w_jalr_sum[XLEN-1:1], 1'b0} : (id_pc_i + id_imm_i);

  assign w_accept     = id_valid_i && id_ready_o && !flush_i;
  assign w_transfer   = r_main_valid && ex_ready_i;
  assign w_misaligned = take_branch_o && (w_target[1:0] != 2'b00);

  assign take_branch_o  = w_accept && w_cond;
  assign pc_bj_target_o = w_target;

  always_comb begin
    w_new       = '0;
    w_new.pc    = id_pc_i;
    w_new.op_a  = w_op_a;
    w_new.op_b  = w_op_b;
    w_new.store = w_fwd_b;
    w_new.instr = id_instruction_i;
    w_new.ctrl  = id_control_i;
    w_new.exc   = w_misaligned;
    w_new.mtval = w_misaligned ? w_target : '0;
  end

  // Skid refills main on transfer; ready only depends on the registered skid bit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= f_rst_bundle();
      r_skid       <= f_rst_bundle();
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_transfer) begin
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main       <= w_new;
        r_main_valid <= 1'b1;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_valid) begin
        r_main       <= w_new;
        r_main_valid <= 1'b1;
      end else begin
        r_skid       <= w_new;
        r_skid_valid <= 1'b1;
      end
    end
  end

  assign id_ready_o       = !r_skid_valid;
  assign ex_valid_o       = r_main_valid;
  assign ex_pc_o          = r_main.pc;
  assign ex_operand_a_o   = r_main.op_a;
  assign ex_operand_b_o   = r_main.op_b;
  assign ex_store_data_o  = r_main.store;
  assign ex_instruction_o = r_main.instr;
  assign ex_control_o     = r_main.ctrl;
  assign ex_exception_o   = r_main.exc;
  assign ex_mtval_o       = r_main.mtval;

  a_fwd_sel_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (id_valid_i && id_ready_o) |-> ((id_fwd_a_sel_i <= SELW'(NFWD)) && (id_fwd_b_sel_i <= SELW'(NFWD))))
    else $error("forward select out of range");

  a_branch_gate: assert property (@(posedge clk_i) disable iff (!rst_ni)
    take_branch_o |-> (id_ready_o && !flush_i))
    else $error("redirect while not accepting");

  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ex_valid_o && !ex_ready_i && !flush_i) |=> (r_main == $past(r_main)))
    else $error("bundle changed under stall");

endmodule
`default_nettype wire

// File: doc/mirfak_id_skid_stage.md
Name: mirfak_id_skid_stage

Overview:
Parametrised successor to the fixed single-register ID/EX boundary. It selects forwarded operands from NFWD generic bypass sources and resolves branches and jumps in ID. It then hands a decoded bundle to EX over a valid/ready handshake. A 2-entry skid buffer lets EX apply back-pressure without a combinational ready path back into ID. The register file stays outside the block; read data arrives on ports.

Parameters:
XLEN, 32, datapath width (32 or 64)
NFWD, 3, number of bypass sources besides the register file (1..7)
CTRL_W, 32, width of the opaque control bundle passed to EX
SELW, 3, width of the forward selects; must satisfy 2**SELW >= NFWD+1

Ports:
clk_i  in  1  clock
rst_ni  in  1  synchronous active-low reset
flush_i  in  1  drop every held and incoming entry
id_valid_i  in  1  ID holds a valid instruction
id_ready_o  out  1  stage can accept; registered, equals !skid_valid
id_pc_i  in  XLEN  instruction PC
id_instruction_i  in  32  raw instruction
id_imm_i  in  XLEN  sign-extended immediate, already selected
id_rs1_data_i / id_rs2_data_i  in  XLEN  register-file read data
id_fwd_data_i  in  NFWD*XLEN  bypass data; source k occupies [k*XLEN +: XLEN]
id_fwd_a_sel_i / id_fwd_b_sel_i  in  SELW  0 selects the register file; k selects source k-1
id_sel_op_a_i  in  2  0 fwd-a, 1 pc, 2 pc+4, 3 zero
id_sel_op_b_i  in  2  0 fwd-b, 1 imm, 2 const 4, 3 zero
id_br_op_i  in  3  0 none, 1 BEQ, 2 BNE, 3 JUMP, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU
id_is_jalr_i  in  1  jump target = (fwd_a + imm) & ~1; otherwise pc + imm
id_control_i  in  CTRL_W  passed through to EX unchanged
ex_valid_o  out  1  output bundle is valid
ex_ready_i  in  1  EX accepts the bundle
ex_pc_o, ex_operand_a_o, ex_operand_b_o, ex_store_data_o  out  XLEN  bundle; store data = fwd-b
ex_instruction_o  out  32  bundle instruction
ex_control_o  out  CTRL_W  bundle control
ex_exception_o  out  1  branch/jump target misaligned
ex_mtval_o  out  XLEN  faulting target address
take_branch_o  out  1  redirect request, combinational
pc_bj_target_o  out  XLEN  redirect target, combinational

Behaviour:
- Accept = id_valid_i && id_ready_o && !flush_i. Transfer = ex_valid_o && ex_ready_i.
- Forward select values above NFWD: output is X (assertion fires). Operand muxes follow id_sel_op_*.
- Branch compares use fwd-a and fwd-b; signed and unsigned variants per id_br_op_i.
- take_branch_o = Accept && (condition true || op==JUMP).
  - Asserted only in the accept cycle.
  - Never asserted while flush_i is high or id_ready_o is low.
- Misalignment is checked on target bits [1:0] (no compressed-instruction support).
  - If take_branch_o is high and the target is misaligned: set ex_exception_o and ex_mtval_o = target in the bundle.
  - take_branch_o still pulses; the exception unit owns recovery.
- Storage: main entry (drives the ex_* outputs) and skid entry.
  - Accept when main is empty or a Transfer occurs: load main.
  - Accept when main is full and there is no Transfer: load skid.
  - Transfer with skid full: skid moves to main, skid is emptied.
  - Accept is impossible while skid is full, because id_ready_o is low.
- Latency: 1 cycle from Accept to ex_valid_o when main is empty.
- Throughput: 1 per cycle while ex_ready_i is held high.
- ex_* outputs stay stable while ex_valid_o && !ex_ready_i.
- flush_i: next cycle main and skid are empty, ex_valid_o=0, id_ready_o=1. Flush beats a simultaneous Accept and Transfer; the incoming instruction is dropped.
- Reset (rst_ni low at clk edge), applied over any state, mid-stall included:
  - ex_valid_o=0, id_ready_o=1, skid empty.
  - ex_instruction_o=32'h00000013 (NOP).
  - ex_control_o=0, ex_exception_o=0.
  - ex_pc_o, operands, ex_store_data_o and ex_mtval_o = 0.
- Data registers only update on load; the valid bits gate meaning.

Test Plan:
- Stream 4 ADDs with ex_ready_i=1 and fwd sel 0 -> ex_valid_o high from cycle 1; operands match rs data; id_ready_o never drops.
- Hold ex_ready_i=0 while presenting 3 instrs -> first two captured (main, skid); id_ready_o=0 from cycle 2; third held. Raise ready -> order preserved 1,2,3 with no duplicates.
- BEQ with fwd_a_sel=2 (source 1 = 0x55) and fwd_b_sel=0 (rs2 = 0x55), pc=0x100, imm=0x20 -> take_branch_o=1, target 0x120, ex_exception_o=0.
- JALR with fwd-a=0x203 and imm=0 -> target 0x202; take_branch_o=1; ex_exception_o=1; ex_mtval_o=0x202.
- Main and skid full, then flush_i with id_valid_i=1 -> next cycle ex_valid_o=0, id_ready_o=1, take_branch_o=0, nothing leaks.
- Reset low during a stall with both entries full -> next cycle ex_valid_o=0, ex_instruction_o=0x00000013, id_ready_o=1.
